// File: rtl/out_sig_compactor.sv
// Folds each valid output word to SIG_W bits and compacts it into a MISR over a
// programmed number of samples, presenting one signature per run.
module out_sig_compactor #(
    parameter int unsigned IN_W  = 330,
    parameter int unsigned SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(32'h04C11DB7),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(32'hFFFFFFFF),
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_cycles,
    input  logic             clear,
    input  logic             sig_ack,
    output logic             busy,
    output logic             sig_valid,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] sample_count
);

    localparam int unsigned N_CHUNK = (IN_W + SIG_W - 1) / SIG_W;
    localparam int unsigned PAD_W   = N_CHUNK * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cfg_q;

    logic [PAD_W-1:0] padded_c;
    logic [SIG_W-1:0] fold_c;
    logic [SIG_W-1:0] sig_step_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // XOR-fold of the zero-padded input word, then one MISR step on the current signature
    always_comb begin
        padded_c = PAD_W'(in_data);
        fold_c   = '0;
        for (int k = 0; k < int'(N_CHUNK); k++) begin
            fold_c = fold_c ^ padded_c[k*SIG_W +: SIG_W];
        end
        sig_step_c = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ fold_c;
        cnt_inc_c  = sample_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sig_valid    <= 1'b0;
            signature    <= SEED;
            sample_count <= '0;
            cfg_q        <= '0;
        end else if (clear) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sig_valid    <= 1'b0;
            signature    <= SEED;
            sample_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cfg_q        <= cfg_cycles;
                        signature    <= SEED;
                        sample_count <= '0;
                        // A zero-length run finishes immediately with the seed as its signature
                        if (cfg_cycles == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            sig_valid <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            sig_valid <= 1'b0;
                        end
                    end else if (state == DONE && sig_ack) begin
                        state     <= IDLE;
                        sig_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        signature    <= sig_step_c;
                        sample_count <= cnt_inc_c;
                        if (cnt_inc_c == cfg_q) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            sig_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sig_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_sig_compactor.sv
// Directed self-checking bench for out_sig_compactor: reset, fold coverage,
// stalls, handshake boundaries and abort paths.
module tb_out_sig_compactor;

    localparam int unsigned IN_W  = 330;
    localparam int unsigned SIG_W = 32;
    localparam int unsigned CNT_W = 32;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'hFFFFFFFF;

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             start;
    logic [CNT_W-1:0] cfg_cycles;
    logic             clear;
    logic             sig_ack;
    logic             busy;
    logic             sig_valid;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] sample_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    out_sig_compactor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .start        (start),
        .cfg_cycles   (cfg_cycles),
        .clear        (clear),
        .sig_ack      (sig_ack),
        .busy         (busy),
        .sig_valid    (sig_valid),
        .signature    (signature),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference fold computed bit by bit: output bit j collects every input bit i with i mod 32 == j
    function automatic logic [31:0] fold_m(input logic [IN_W-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < int'(IN_W); i++) f[i % 32] = f[i % 32] ^ d[i];
        return f;
    endfunction

    function automatic logic [31:0] step_m(input logic [31:0] s, input logic [IN_W-1:0] d);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ POLY;
        return r ^ fold_m(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] cfg);
        start      = 1'b1;
        cfg_cycles = cfg;
        tick();
        start      = 1'b0;
    endtask

    task automatic one_sample(input logic [IN_W-1:0] d);
        start_run(32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic ack();
        sig_ack = 1'b1;
        tick();
        sig_ack = 1'b0;
    endtask

    logic [IN_W-1:0] d0;
    logic [IN_W-1:0] dk;
    logic [31:0]     exp_sig;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_cycles = 32'd7;
        clear      = 1'b0;
        sig_ack    = 1'b0;
        d0         = {10'h2AB, {10{32'hDEADBEEF}}};

        // Reset held with start asserted
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sig_valid", 32'(sig_valid), 32'd0);
        check("rst_signature", signature, 32'hFFFFFFFF);
        check("rst_count", sample_count, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();

        // Single-sample runs covering fold boundaries
        one_sample('0);
        check("zero_sig_valid", 32'(sig_valid), 32'd1);
        check("zero_signature", signature, 32'hFB3EE249);
        check("zero_count", sample_count, 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        ack();
        check("ack_sig_valid", 32'(sig_valid), 32'd0);
        check("ack_sig_hold", signature, 32'hFB3EE249);
        check("ack_count_hold", sample_count, 32'd1);

        dk = '0; dk[0] = 1'b1;
        one_sample(dk);
        check("bit0_signature", signature, 32'hFB3EE248);
        ack();
        dk = '0; dk[32] = 1'b1;
        one_sample(dk);
        check("bit32_signature", signature, 32'hFB3EE248);
        ack();
        dk = '0; dk[329] = 1'b1;
        one_sample(dk);
        check("bit329_signature", signature, 32'hFB3EE049);
        ack();

        // Gap-free 3-sample run
        exp_sig = step_m(step_m(step_m(SEED, d0), d0), d0);
        start_run(32'd3);
        check("run_busy", 32'(busy), 32'd1);
        in_data  = d0;
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("nogap_signature", signature, exp_sig);
        check("nogap_sig_valid", 32'(sig_valid), 32'd1);
        ack();

        // Same data with valid pattern 1,0,0,1,1
        start_run(32'd3);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        tick();
        check("stall_count_mid", sample_count, 32'd1);
        in_valid = 1'b1; tick();
        check("stall_sig_valid_e4", 32'(sig_valid), 32'd0);
        check("stall_count_e4", sample_count, 32'd2);
        tick();
        in_valid = 1'b0;
        check("stall_sig_valid_e5", 32'(sig_valid), 32'd1);
        check("stall_busy_e5", 32'(busy), 32'd0);
        check("stall_count_e5", sample_count, 32'd3);
        check("stall_signature", signature, exp_sig);

        // Samples while DONE are discarded; sig_valid held without ack
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_sig_valid", 32'(sig_valid), 32'd1);
        end
        in_valid = 1'b0;
        check("hold_signature", signature, exp_sig);
        check("hold_count", sample_count, 32'd3);

        // start and sig_ack together: new run wins
        sig_ack = 1'b1;
        start_run(32'd2);
        sig_ack = 1'b0;
        check("startack_sig_valid", 32'(sig_valid), 32'd0);
        check("startack_busy", 32'(busy), 32'd1);
        check("startack_signature", signature, SEED);
        check("startack_count", sample_count, 32'd0);
        in_data  = d0;
        in_valid = 1'b1;
        tick();
        // start during RUN must not relatch cfg
        start = 1'b1; cfg_cycles = 32'd9;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("ignore_start_sig_valid", 32'(sig_valid), 32'd1);
        check("ignore_start_signature", signature, step_m(step_m(SEED, d0), d0));

        // cfg_cycles = 0 from DONE
        start_run(32'd0);
        check("cfg0_sig_valid", 32'(sig_valid), 32'd1);
        check("cfg0_signature", signature, 32'hFFFFFFFF);
        check("cfg0_count", sample_count, 32'd0);
        check("cfg0_busy", 32'(busy), 32'd0);
        ack();

        // Abort with clear after 2 of 5 samples, clear beating start and in_valid
        start_run(32'd5);
        in_data  = d0;
        in_valid = 1'b1;
        tick(); tick();
        check("abort_count_pre", sample_count, 32'd2);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_sig_valid", 32'(sig_valid), 32'd0);
        check("clear_signature", signature, 32'hFFFFFFFF);
        check("clear_count", sample_count, 32'd0);
        tick();
        check("clear_stays_idle", 32'(busy), 32'd0);

        // Same abort via rst_n
        start_run(32'd5);
        in_valid = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check("rstabort_busy", 32'(busy), 32'd0);
        check("rstabort_signature", signature, 32'hFFFFFFFF);
        check("rstabort_count", sample_count, 32'd0);

        // Fresh 5-sample run with varying data against the golden model
        exp_sig = SEED;
        dk      = d0;
        start_run(32'd5);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = dk;
            exp_sig = step_m(exp_sig, dk);
            tick();
            dk = {dk[IN_W-2:0], dk[IN_W-1]} ^ IN_W'(k * 32'h1357);
        end
        in_valid = 1'b0;
        check("fresh_sig_valid", 32'(sig_valid), 32'd1);
        check("fresh_count", sample_count, 32'd5);
        check("fresh_signature", signature, exp_sig);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
